// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the skid-buffered pipeline stage: state encodings and control levels.
package pipe_skid_stage_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } state_t;

    localparam logic RST_LEVEL  = 1'b1;
    localparam logic LOAD_LEVEL = 1'b1;

endpackage

// File: rtl/pipe_skid_stage_data_reg.sv
// Payload register with synchronous clear and load enable; used for both main and skid slots.
module pipe_data_reg
    import pipe_skid_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst == RST_LEVEL) begin
            q <= '0;
        end else if (load == LOAD_LEVEL) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid stage with registered in_ready/out_valid; optional flush port when
// PIPE_SKID_FLUSH_EN is defined.
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_FLUSH_EN
    ,
    input  logic             flush
`endif
);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             emit;
    logic             flush_now;
    logic             main_load;
    logic             skid_load;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;

`ifdef PIPE_SKID_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    assign accept = in_valid && in_ready;
    assign emit   = out_valid && out_ready;

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (accept) state_next = BUSY;
            BUSY: begin
                if (accept && !emit)      state_next = FULL;
                else if (!accept && emit) state_next = EMPTY;
            end
            FULL:    if (emit) state_next = BUSY;
            default: state_next = EMPTY;
        endcase
        if (flush_now) state_next = EMPTY;
    end

    // Flush leaves payload registers untouched; only control is cleared.
    assign main_load = !flush_now &&
                       ((accept && (state == EMPTY || emit)) || (state == FULL && emit));
    assign skid_load = !flush_now && accept && (state == BUSY) && !emit;
    assign main_d    = (state == FULL) ? skid_q : in_data;

    always_ff @(posedge clk) begin
        if (rst == RST_LEVEL) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_next;
            out_valid <= (state_next != EMPTY);
            in_ready  <= (state_next != FULL);
        end
    end

    pipe_data_reg #(.WIDTH(WIDTH)) u_main (
        .clk  (clk),
        .rst  (rst),
        .load (main_load),
        .d    (main_d),
        .q    (out_data)
    );

    pipe_data_reg #(.WIDTH(WIDTH)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (skid_load),
        .d    (in_data),
        .q    (skid_q)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed vector table, corner sequences and a queue-model random run.
module tb_pipe_skid_stage;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
`ifdef PIPE_SKID_FLUSH_EN
    logic             flush = 1'b0;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_skid_stage #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_SKID_FLUSH_EN
        ,
        .flush     (flush)
`endif
    );

    typedef struct {
        logic             rst;
        logic             iv;
        logic [WIDTH-1:0] d;
        logic             ordy;
        logic             ov;
        logic             ir;
        logic [WIDTH-1:0] od;
    } vec_t;

    vec_t tbl [13];
    logic [WIDTH-1:0] q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst, in_valid, in_data, out_ready -> out_valid, in_ready, out_data (after the edge)
        tbl[0]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[1]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[2]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[3]  = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 8'h01};
        tbl[4]  = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 1'b1, 8'h02};
        tbl[5]  = '{1'b0, 1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 8'h03};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h03};
        tbl[7]  = '{1'b0, 1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 8'h10};
        tbl[8]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h10};
        tbl[9]  = '{1'b0, 1'b1, 8'h12, 1'b0, 1'b1, 1'b0, 8'h10};
        tbl[10] = '{1'b0, 1'b1, 8'h12, 1'b1, 1'b1, 1'b1, 8'h11};
        tbl[11] = '{1'b0, 1'b1, 8'h12, 1'b1, 1'b1, 1'b1, 8'h12};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h12};

        for (int i = 0; i < 13; i++) begin
            rst       = tbl[i].rst;
            in_valid  = tbl[i].iv;
            in_data   = tbl[i].d;
            out_ready = tbl[i].ordy;
            tick();
            check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].ir));
            check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(tbl[i].od));
        end

        // Reset while FULL discards both held payloads and the reset-cycle offer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h40;
        tick();
        in_data = 8'h41;
        tick();
        check("midfull_in_ready", 32'(in_ready), 32'd0);
        check("midfull_out_valid", 32'(out_valid), 32'd1);
        rst     = 1'b1;
        in_data = 8'h42;
        tick();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_data", 32'(out_data), 32'd0);
        rst       = 1'b0;
        in_data   = 8'h30;
        out_ready = 1'b1;
        tick();
        check("postrst_out_valid", 32'(out_valid), 32'd1);
        check("postrst_out_data", 32'(out_data), 32'h30);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("postrst_idle%0d_out_valid", i), 32'(out_valid), 32'd0);
        end

`ifdef PIPE_SKID_FLUSH_EN
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h20;
        tick();
        in_data = 8'h21;
        tick();
        check("flush_pre_in_ready", 32'(in_ready), 32'd0);
        flush   = 1'b1;
        in_data = 8'h22;
        tick();
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        check("flush_data_hold", 32'(out_data), 32'h20);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("flush_idle%0d_out_valid", i), 32'(out_valid), 32'd0);
        end
`endif

        // Random traffic against a two-deep FIFO model
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            logic acc;
            logic emt;
            logic fl;
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = WIDTH'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
            fl        = 1'b0;
`ifdef PIPE_SKID_FLUSH_EN
            fl    = ($urandom_range(0, 199) == 0);
            flush = fl;
`endif
            acc = in_valid && (q.size() < 2);
            emt = out_ready && (q.size() > 0);
            tick();
            if (fl) begin
                q.delete();
            end else begin
                if (emt) void'(q.pop_front());
                if (acc) q.push_back(in_data);
            end
            check("rnd_out_valid", 32'(out_valid), 32'(q.size() > 0));
            check("rnd_in_ready", 32'(in_ready), 32'(q.size() < 2));
            if (q.size() > 0) check("rnd_out_data", 32'(out_data), 32'(q[0]));
        end
`ifdef PIPE_SKID_FLUSH_EN
        flush = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the payload bit width.
REQ-002 The block SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port in_valid  input  1  upstream offers in_data.
REQ-005 The block SHALL have port in_ready  output  1  block accepts in_data this cycle; registered, no combinational path from out_ready.
REQ-006 The block SHALL have port in_data  input  WIDTH  upstream payload.
REQ-007 The block SHALL have port out_valid  output  1  out_data holds a valid payload; registered.
REQ-008 The block SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-009 The block SHALL have port out_data  output  WIDTH  payload to downstream; registered.
REQ-010 The block SHALL have port flush  input  1  discard all held payloads; present only when PIPE_SKID_FLUSH_EN is defined.

Function
REQ-011 Transfers SHALL occur on cycles with in_valid&&in_ready (accept) or out_valid&&out_ready (emit).
REQ-012 The block SHALL hold a main register (drives out_data) and one skid register, plus a 2-bit state: EMPTY, BUSY (main only), FULL (main+skid).
REQ-013 EMPTY: accept -> main<=in_data, BUSY; no accept -> stay.
REQ-014 BUSY: accept and emit -> main<=in_data, stay BUSY; accept only -> skid<=in_data, FULL; emit only -> EMPTY; neither -> stay.
REQ-015 FULL: emit -> main<=skid, BUSY; no emit -> stay; no accept possible.
REQ-016 out_valid SHALL be 1 exactly in BUSY and FULL; in_ready SHALL be 1 exactly in EMPTY and BUSY (registered next-state decode).
REQ-017 Latency in_data to out_data SHALL be 1 cycle; sustained throughput SHALL be 1 payload/cycle when out_ready is held 1.
REQ-018 Order SHALL be preserved; no payload SHALL be dropped or duplicated; out_data SHALL stay stable while out_valid&&!out_ready.
REQ-019 Data registers SHALL load only on the transfers above; otherwise hold value.
REQ-020 in_valid while in_ready=0 SHALL have no effect; upstream holds payload.

Reset
REQ-021 On a clk edge with rst=1: state EMPTY, out_valid=0, in_ready=1, out_data=0, skid=0.
REQ-022 rst SHALL override all other inputs including flush; an accept presented in the reset cycle SHALL be discarded.
REQ-023 Reset mid-operation (BUSY or FULL) SHALL discard held payloads with no emit afterwards.

Configuration
REQ-024 With PIPE_SKID_FLUSH_EN defined: flush=1 at a clk edge SHALL force state EMPTY, out_valid=0, in_ready=1; any same-cycle accept SHALL be discarded; data registers SHALL hold value; an emit in the flush cycle still completes for downstream.
REQ-025 Without PIPE_SKID_FLUSH_EN: flush port and logic SHALL be absent; behaviour otherwise identical.

Structure
REQ-026 State encodings (EMPTY=2'b00, BUSY=2'b01, FULL=2'b10) and the reset/enable level constants SHALL live in the shared global definitions package.
REQ-027 One sub-module pipe_data_reg (WIDTH-parameterized register with synchronous reset to 0 and load enable) SHALL be instantiated twice (main, skid); control FSM stays in pipe_skid_stage.

Verification
REQ-028 Reset: rst=1 2 cycles, in_valid=1 in_data=0xA5 -> out_valid=0, in_ready=1, out_data=0 after release.
REQ-029 Streaming: out_ready=1, push 0x1,0x2,0x3 back-to-back -> out_data 0x1,0x2,0x3 on consecutive cycles, each 1 cycle after accept.
REQ-030 Backpressure: out_ready=0, push 0x10,0x11,0x12 -> 0x10,0x11 accepted, in_ready=0 after 2nd, 0x12 held; release out_ready -> 0x10,0x11,0x12 in order, none lost.
REQ-031 Random: 10,000 cycles random in_valid/out_ready, WIDTH=8 -> scoreboard order matches, out_data stable while stalled.
REQ-032 Flush (PIPE_SKID_FLUSH_EN): in FULL with 0x20,0x21, flush=1 with in_valid=1 in_data=0x22 -> next cycle out_valid=0, in_ready=1; none of 0x20..0x22 emitted afterwards.
REQ-033 Reset mid-FULL: state FULL, rst=1 1 cycle -> out_valid=0, in_ready=1, next push 0x30 emitted alone.
